// File: rtl/or_reduce_pipe_if.sv
// Bus bundle for or_reduce_pipe: data vector with valid, clock enable, sticky clear,
// and the reduced result with its valid and sticky flag.
interface or_reduce_pipe_if #(
  parameter int WIDTH = 3
);
  logic             CE;
  logic [WIDTH-1:0] I;
  logic             IV;
  logic             SCLR;
  logic             O;
  logic             OV;
  logic             S;

  modport master (
    output CE, I, IV, SCLR,
    input  O, OV, S
  );

  modport slave (
    input  CE, I, IV, SCLR,
    output O, OV, S
  );
endinterface

// File: rtl/or_reduce_pipe.sv
// Masked-inversion OR/NOR reduction tree, pipelined FAN inputs per node; latency STAGES enabled cycles.
// No backpressure: CE=0 freezes every data/valid register, sticky S still clearable by SCLR.
module or_reduce_pipe #(
  parameter int               WIDTH    = 3,
  parameter int               FAN      = 4,
  parameter logic [WIDTH-1:0] INV_MASK = '1,
  parameter bit               INV_OUT  = 1'b0
) (
  input logic           C,
  input logic           R,
  or_reduce_pipe_if.slave bus
);

  function automatic int lvl_n(input int j);
    int n;
    n = WIDTH;
    for (int s = 0; s < j; s++) n = (n + FAN - 1) / FAN;
    return n;
  endfunction

  // At least one stage even when WIDTH=1, so the output is always registered.
  function automatic int num_stages();
    int n;
    int st;
    n  = WIDTH;
    st = 0;
    while (st == 0 || n > 1) begin
      n  = (n + FAN - 1) / FAN;
      st = st + 1;
    end
    return st;
  endfunction

  localparam int STAGES = num_stages();

  logic [WIDTH-1:0] x;
  logic             s_q;

  assign x = bus.I ^ INV_MASK;

  for (genvar j = 0; j < STAGES; j++) begin : g_stg
    localparam int NI = lvl_n(j);
    localparam int NO = lvl_n(j + 1);

    logic [NI-1:0]     src;
    logic              src_v;
    logic [NO*FAN-1:0] pad;
    logic [NO-1:0]     d;
    logic [NO-1:0]     q;
    logic              v;

    if (j == 0) begin : g_in
      assign src   = x;
      assign src_v = bus.IV;
    end else begin : g_chain
      assign src   = g_stg[j-1].q;
      assign src_v = g_stg[j-1].v;
    end

    // Zero-pad the last node's missing inputs so every node sees exactly FAN bits.
    always_comb begin
      pad          = '0;
      pad[NI-1:0]  = src;
    end

    always_comb begin
      d = '0;
      for (int m = 0; m < NO; m++) d[m] = |pad[m*FAN +: FAN];
    end

    always_ff @(posedge C) begin
      if (R) begin
        q <= '0;
        v <= 1'b0;
      end else if (bus.CE) begin
        q <= d;
        v <= src_v;
      end
    end
  end

  assign bus.O  = g_stg[STAGES-1].q[0] ^ INV_OUT;
  assign bus.OV = g_stg[STAGES-1].v;
  assign bus.S  = s_q;

  // Set has priority over clear so an alarm coinciding with SCLR is never lost.
  always_ff @(posedge C) begin
    if (R) begin
      s_q <= 1'b0;
    end else if (bus.CE && bus.OV && bus.O) begin
      s_q <= 1'b1;
    end else if (bus.SCLR) begin
      s_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed bench for or_reduce_pipe: an 8-bit/FAN=2 instance and a default 3-bit NOR instance.
module tb_or_reduce_pipe;

  typedef struct {
    logic o;
    int   due;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ent_t qa[$];
  ent_t qb[$];
  int   ecnt_a = 0;
  int   ecnt_b = 0;
  logic ma_o = 1'b0, ma_ov = 1'b0, sa = 1'b0;
  logic mb_o = 1'b1, mb_ov = 1'b0, sb = 1'b0;

  or_reduce_pipe_if #(.WIDTH(8)) bus_a ();
  or_reduce_pipe_if #(.WIDTH(3)) bus_b ();

  or_reduce_pipe #(.WIDTH(8), .FAN(2), .INV_MASK(8'h07), .INV_OUT(1'b0)) dut_a (
    .C  (clk),
    .R  (rst),
    .bus(bus_a)
  );

  or_reduce_pipe #(.WIDTH(3), .FAN(4), .INV_OUT(1'b1)) dut_b (
    .C  (clk),
    .R  (rst),
    .bus(bus_b)
  );

  always #5 clk = ~clk;

  function automatic logic ra(input logic [7:0] i);
    return |(i ^ 8'h07);
  endfunction

  function automatic logic rb(input logic [2:0] i);
    return ~(|(i ^ 3'b111));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] ia, input logic iva, input logic cea,
                      input logic r, input logic sclr);
    ent_t e;
    bus_a.I    = ia;
    bus_a.IV   = iva;
    bus_a.CE   = cea;
    bus_a.SCLR = sclr;
    rst        = r;
    if (!r && cea && iva) qa.push_back('{o: ra(ia), due: ecnt_a + 3});
    if (!r && bus_b.CE && bus_b.IV) qb.push_back('{o: rb(bus_b.I), due: ecnt_b + 1});
    @(posedge clk);
    #1;
    if (r) begin
      qa.delete();
      qb.delete();
      ma_ov = 1'b0; ma_o = 1'b0; sa = 1'b0;
      mb_ov = 1'b0; mb_o = 1'b1; sb = 1'b0;
    end else begin
      if (cea && ma_ov && ma_o) sa = 1'b1;
      else if (sclr) sa = 1'b0;
      if (cea) begin
        ecnt_a++;
        if (qa.size() > 0 && qa[0].due == ecnt_a) begin
          e = qa.pop_front();
          ma_ov = 1'b1;
          ma_o  = e.o;
        end else begin
          ma_ov = 1'b0;
        end
      end
      if (bus_b.CE && mb_ov && mb_o) sb = 1'b1;
      else if (bus_b.SCLR) sb = 1'b0;
      if (bus_b.CE) begin
        ecnt_b++;
        if (qb.size() > 0 && qb[0].due == ecnt_b) begin
          e = qb.pop_front();
          mb_ov = 1'b1;
          mb_o  = e.o;
        end else begin
          mb_ov = 1'b0;
        end
      end
    end
    chk("ov_a", bus_a.OV, ma_ov);
    if (ma_ov || r) chk("o_a", bus_a.O, ma_o);
    chk("s_a", bus_a.S, sa);
    chk("ov_b", bus_b.OV, mb_ov);
    if (mb_ov || r) chk("o_b", bus_b.O, mb_o);
    chk("s_b", bus_b.S, sb);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus_a.I = '0; bus_a.IV = 1'b0; bus_a.CE = 1'b1; bus_a.SCLR = 1'b0;
    bus_b.I = '0; bus_b.IV = 1'b0; bus_b.CE = 1'b1; bus_b.SCLR = 1'b0;

    // reset held two cycles with live-looking inputs
    step(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
    step(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);

    // first vector and input inversion
    step(8'h07, 1'b1, 1'b1, 1'b0, 1'b0); idle(3);
    step(8'h03, 1'b1, 1'b1, 1'b0, 1'b0); idle(3);
    step(8'h87, 1'b1, 1'b1, 1'b0, 1'b0); idle(3);

    // back-to-back throughput
    step(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h06, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // clear sticky alone
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

    // stall between two injections
    step(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(8'hff, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    // sticky: clear, then set coinciding with clear
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

    // reset with two vectors in flight, then recovery
    step(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    step(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // default-mask NOR instance, single stage
    bus_b.I = 3'b111; bus_b.IV = 1'b1;
    idle(1);
    bus_b.I = 3'b000;
    idle(1);
    bus_b.IV = 1'b0;
    idle(2);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/or_reduce_pipe.md
Name: or_reduce_pipe

Overview:
- Parametrised successor to the fixed 3-input OR gates with inverted inputs.
- Reduces a WIDTH-bit input vector to one bit: per-input inversion set by a mask, optional output inversion for NOR.
- The OR tree is pipelined at a selectable fan-in so wide reductions meet timing.
- Carries a valid bit through the pipeline, supports a clock-enable stall, and keeps a sticky "any-one-seen" flag for fault/alarm aggregation in fabric logic.

Parameters:
- WIDTH, 3, number of input bits (>=1).
- FAN, 4, OR inputs per tree node per pipeline stage (>=2).
- INV_MASK, all ones (WIDTH bits), bit k=1 inverts I[k] before reduction; default equals 3-input all-inverted OR behaviour.
- INV_OUT, 0, 1 inverts the reduced result (NOR).

Ports:
- C  input  1  clock, all state on rising edge.
- R  input  1  synchronous reset, active-high.
- CE  input  1  clock enable for pipeline and sticky set.
- I  input  WIDTH  data vector.
- IV  input  1  I valid this cycle.
- O  output  1  reduced result.
- OV  output  1  O valid.
- S  output  1  sticky flag.
- SCLR  input  1  sticky clear.

Behaviour:
- Reset and clock: one clock C; reset R is synchronous and active-high.
- Reset on R=1 at an edge:
  - all stage registers cleared to 0 and all valid bits to 0;
  - O = INV_OUT, OV=0, S=0;
  - R overrides CE, IV and SCLR.
- Input conditioning: X[k] = I[k] XOR INV_MASK[k], combinational, ahead of stage 1.
- Stage structure:
  - N0=WIDTH; Nj=ceil(N(j-1)/FAN); STAGES = number of j until Nj=1, minimum 1 (WIDTH=1 gives 1 stage).
  - Stage j registers Nj partial ORs. Node m ORs inputs m*FAN..m*FAN+FAN-1 of the previous level.
  - Missing inputs pad with 0.
- Output: O = final register XOR INV_OUT.
- Latency: exactly STAGES enabled cycles from IV sampled (CE=1) to OV=1 with that vector's result. Examples: WIDTH=8, FAN=2 gives 3; WIDTH=3, FAN=4 gives 1.
- Throughput: one vector per enabled cycle, no bubbles.
- Valid handling:
  - valid shifts alongside data;
  - stage data registers load every enabled cycle regardless of valid;
  - O is meaningful only when OV=1.
- CE=0: every data and valid register holds; O and OV hold their values.
- Sticky flag S:
  - on an edge with CE=1, OV=1 and O=1, S becomes 1 on the next cycle;
  - SCLR=1 clears S regardless of CE;
  - set and SCLR in the same cycle leaves S=1, so set wins and no event is lost;
  - SCLR does not touch the pipeline.
- R mid-flight: in-flight vectors are discarded; OV stays 0 until a new IV has travelled STAGES enabled cycles.
- IV=0 with CE=1: a bubble propagates and OV=0 at the matching output cycle.

Test Plan:
1. Reset (WIDTH=8, FAN=2, INV_MASK=8'h07, INV_OUT=0): hold R=1 for 2 cycles with random I, IV=1, SCLR=0 -> O=0, OV=0, S=0; first OV=1 appears exactly 3 cycles after the first post-reset IV.
2. Inversion:
   - I=8'h07, IV=1 for one cycle -> 3 cycles later OV=1, O=0;
   - then I=8'h03 -> O=1 3 cycles later;
   - then I=8'h87 -> O=1 (bit 7).
3. Throughput: IV=1 for 6 consecutive cycles with I = 07, 03, 07, 80, 07, 06 -> OV=1 for 6 consecutive cycles starting at latency 3, O = 0, 1, 0, 1, 0, 1.
4. Stall:
   - inject 8'h03 then 8'h07;
   - drop CE for 4 cycles after the first injection -> O and OV frozen;
   - results emerge in order with latency counted in enabled cycles only (3 + 4 stall).
5. Sticky:
   - result O=1 with OV=1 -> S=1 next cycle and held through later O=0 results;
   - SCLR=1 alone -> S=0;
   - SCLR=1 coincident with an O=1/OV=1 edge -> S stays 1.
6. Reset mid-flight and defaults:
   - R=1 for one cycle while 2 vectors are in flight -> neither produces OV;
   - with WIDTH=3, FAN=4, INV_OUT=1, default mask: I=3'b111 -> O=1, I=3'b000 -> O=0 one cycle later.
